// File: rtl/fsm_step_arbiter_if.sv
// Requester/arbiter/FSM signal bundle for the stepped-FSM arbiter.
// The master side is the requesters plus the FSM; the slave side is the arbiter.
interface fsm_step_arbiter_if #(
    parameter int CNT_W = 16
);
    logic [2:0]       req;
    logic [8:0]       req_x;
    logic [2:0]       req_lock;
    logic             clr;
    logic [2:0]       gnt;
    logic             fsm_x1;
    logic             fsm_x2;
    logic             fsm_x3;
    logic             fsm_nreset;
    logic [2:0]       fsm_y;
    logic [2:0]       fsm_z;
    logic             rsp_valid;
    logic [1:0]       rsp_id;
    logic [2:0]       rsp_y;
    logic [2:0]       rsp_z;
    logic [CNT_W-1:0] step_cnt;

    modport master (
        output req, req_x, req_lock, clr, fsm_y, fsm_z,
        input  gnt, fsm_x1, fsm_x2, fsm_x3, fsm_nreset,
               rsp_valid, rsp_id, rsp_y, rsp_z, step_cnt
    );

    modport slave (
        input  req, req_x, req_lock, clr, fsm_y, fsm_z,
        output gnt, fsm_x1, fsm_x2, fsm_x3, fsm_nreset,
               rsp_valid, rsp_id, rsp_y, rsp_z, step_cnt
    );
endinterface

// File: rtl/fsm_step_arbiter.sv
// Round-robin (with lock) arbiter sharing one stepped FSM among three requesters.
// A grant in cycle n drives the FSM in n+1 and returns its state/output in n+2.

module fsm_step_arbiter_lane (
    input  logic       gnt,
    input  logic       holder,
    input  logic       req,
    input  logic       lock,
    input  logic [2:0] x_slice,
    output logic       lock_hit,
    output logic [2:0] x_sel
);
    assign lock_hit = holder & req & lock;
    assign x_sel    = gnt ? x_slice : 3'b000;
endmodule

module fsm_step_arbiter #(
    parameter logic [2:0] IDLE_X = 3'b000,
    parameter int         CNT_W  = 16
) (
    input logic               clk,
    input logic               nreset,
    fsm_step_arbiter_if.slave bus
);
    localparam int NUM_REQ = 3;
    localparam int STAGES  = 2;

    logic [NUM_REQ-1:0]      last_oh;
    logic [1:0]              ptr;
    logic [NUM_REQ-1:0]      lock_hit;
    logic [NUM_REQ-1:0]      rr_oh;
    logic [NUM_REQ-1:0]      gnt_oh;
    logic [NUM_REQ-1:0][2:0] x_sel;
    logic [2:0]              x_gnt;
    logic [1:0]              gnt_id;
    logic                    gnt_any;
    logic                    run;
    logic [STAGES:1]         vld_pipe;
    logic [STAGES:1][1:0]    id_pipe;
    logic [2:0]              fsm_x_q;
    logic                    fsm_nreset_q;
    logic [CNT_W-1:0]        step_cnt_q;

    function automatic logic [1:0] rr_idx(input logic [1:0] base, input int k);
        int unsigned s;
        s = (32'(base) + 32'(k)) % 32'(NUM_REQ);
        return s[1:0];
    endfunction

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
        fsm_step_arbiter_lane u_lane (
            .gnt      (gnt_oh[i]),
            .holder   (last_oh[i]),
            .req      (bus.req[i]),
            .lock     (bus.req_lock[i]),
            .x_slice  (bus.req_x[3*i +: 3]),
            .lock_hit (lock_hit[i]),
            .x_sel    (x_sel[i])
        );
    end

    // Walk from lowest to highest priority so the highest-priority hit is written last.
    always_comb begin
        rr_oh = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (bus.req[rr_idx(ptr, k)]) begin
                rr_oh                 = '0;
                rr_oh[rr_idx(ptr, k)] = 1'b1;
            end
        end
    end

    assign run     = nreset & ~bus.clr;
    assign gnt_oh  = !run ? '0 : (|lock_hit) ? last_oh : rr_oh;
    assign gnt_any = |gnt_oh;
    assign gnt_id  = {gnt_oh[2], gnt_oh[1]};

    always_comb begin
        x_gnt = '0;
        for (int i = 0; i < NUM_REQ; i++) x_gnt = x_gnt | x_sel[i];
    end

    // A released lock resumes at holder+1, which is exactly where ptr already points.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            ptr          <= '0;
            last_oh      <= '0;
            vld_pipe     <= '0;
            id_pipe      <= '0;
            fsm_x_q      <= IDLE_X;
            fsm_nreset_q <= 1'b0;
            step_cnt_q   <= '0;
        end else begin
            vld_pipe     <= {vld_pipe[STAGES-1:1], gnt_any};
            id_pipe      <= {id_pipe[STAGES-1:1], gnt_id};
            fsm_x_q      <= gnt_any ? x_gnt : IDLE_X;
            fsm_nreset_q <= ~bus.clr;
            if (vld_pipe[STAGES]) step_cnt_q <= step_cnt_q + CNT_W'(1);
            if (gnt_any) begin
                last_oh <= gnt_oh;
                ptr     <= (gnt_id == 2'd2) ? 2'd0 : gnt_id + 2'd1;
            end
        end
    end

    assign bus.gnt                            = gnt_oh;
    assign {bus.fsm_x1, bus.fsm_x2, bus.fsm_x3} = fsm_x_q;
    assign bus.fsm_nreset                     = fsm_nreset_q;
    assign bus.rsp_valid                      = vld_pipe[STAGES];
    assign bus.rsp_id                         = id_pipe[STAGES];
    assign bus.rsp_y                          = bus.fsm_y;
    assign bus.rsp_z                          = bus.fsm_z;
    assign bus.step_cnt                       = step_cnt_q;
endmodule

// File: tb/tb_fsm_step_arbiter.sv
// Bench for fsm_step_arbiter: directed scenarios plus a randomized run against a cycle model.
// The controlled FSM is a stand-in accumulator: y += x each step, z echoes the applied x.
module tb_fsm_step_arbiter;
    localparam int         CNT_W  = 4;
    localparam logic [2:0] IDLE_X = 3'b000;

    logic       clk    = 1'b0;
    logic       nreset = 1'b0;
    int         checks = 0;
    int         errors = 0;
    logic [2:0] fy, fz, fx;

    fsm_step_arbiter_if #(.CNT_W(CNT_W)) bus ();
    fsm_step_arbiter #(.IDLE_X(IDLE_X), .CNT_W(CNT_W)) dut (.clk(clk), .nreset(nreset), .bus(bus));

    always #5 clk = ~clk;

    assign fx = {bus.fsm_x1, bus.fsm_x2, bus.fsm_x3};
    always @(posedge clk) begin
        if (!bus.fsm_nreset) begin
            fy <= 3'b000;
            fz <= 3'b000;
        end else begin
            fy <= fy + fx;
            fz <= fx;
        end
    end
    assign bus.fsm_y = fy;
    assign bus.fsm_z = fz;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        nreset = 1'b0; bus.req = '0; bus.req_x = '0; bus.req_lock = '0; bus.clr = 1'b0;
        repeat (2) @(posedge clk);
        #1 nreset = 1'b1;
        next_cycle();
    endtask

    task automatic test_reset();
        nreset = 1'b0; bus.req = 3'b111; bus.req_lock = 3'b111; bus.req_x = '1; bus.clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        checks++; if (bus.gnt !== 3'b000) begin errors++; $display("FAIL reset_gnt got %b want 000", bus.gnt); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", bus.rsp_valid); end
        checks++; if (bus.rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_id got %0d want 0", bus.rsp_id); end
        checks++; if (bus.step_cnt !== '0) begin errors++; $display("FAIL reset_step_cnt got %0d want 0", bus.step_cnt); end
        checks++; if (bus.fsm_nreset !== 1'b0) begin errors++; $display("FAIL reset_fsm_nreset got %b want 0", bus.fsm_nreset); end
        checks++; if (fx !== IDLE_X) begin errors++; $display("FAIL reset_fsm_x got %b want %b", fx, IDLE_X); end
        next_cycle();
        nreset = 1'b1; bus.req = '0; bus.req_lock = '0;
        @(negedge clk);
        checks++; if (bus.fsm_nreset !== 1'b0) begin errors++; $display("FAIL release_fsm_nreset_first got %b want 0", bus.fsm_nreset); end
        next_cycle();
        @(negedge clk);
        checks++; if (bus.fsm_nreset !== 1'b1) begin errors++; $display("FAIL release_fsm_nreset_second got %b want 1", bus.fsm_nreset); end
        next_cycle();
    endtask

    task automatic test_single();
        do_reset();
        bus.req = 3'b001; bus.req_x = 9'b000_000_100;
        @(negedge clk);
        checks++; if (bus.gnt !== 3'b001) begin errors++; $display("FAIL single_gnt0 got %b want 001", bus.gnt); end
        next_cycle();
        bus.req = 3'b010; bus.req_x = 9'b000_010_000;
        @(negedge clk);
        checks++; if (bus.gnt !== 3'b010) begin errors++; $display("FAIL single_gnt1 got %b want 010", bus.gnt); end
        checks++; if (fx !== 3'b100) begin errors++; $display("FAIL single_fsm_x0 got %b want 100", fx); end
        next_cycle();
        bus.req = 3'b000;
        @(negedge clk);
        checks++; if ({bus.rsp_valid, bus.rsp_id} !== 3'b100) begin errors++; $display("FAIL single_rsp0 got v%b id%0d want v1 id0", bus.rsp_valid, bus.rsp_id); end
        checks++; if ({bus.rsp_y, bus.rsp_z} !== 6'b100_100) begin errors++; $display("FAIL single_rsp0_yz got %b/%b want 100/100", bus.rsp_y, bus.rsp_z); end
        checks++; if (fx !== 3'b010) begin errors++; $display("FAIL single_fsm_x1 got %b want 010", fx); end
        next_cycle();
        @(negedge clk);
        checks++; if ({bus.rsp_valid, bus.rsp_id} !== 3'b101) begin errors++; $display("FAIL single_rsp1 got v%b id%0d want v1 id1", bus.rsp_valid, bus.rsp_id); end
        checks++; if ({bus.rsp_y, bus.rsp_z} !== 6'b110_010) begin errors++; $display("FAIL single_rsp1_yz got %b/%b want 110/010", bus.rsp_y, bus.rsp_z); end
        checks++; if (fx !== IDLE_X) begin errors++; $display("FAIL single_idle_x got %b want %b", fx, IDLE_X); end
        next_cycle();
        @(negedge clk);
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL single_no_rsp got %b want 0", bus.rsp_valid); end
        checks++; if (bus.step_cnt !== CNT_W'(2)) begin errors++; $display("FAIL single_step_cnt got %0d want 2", bus.step_cnt); end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        logic [2:0] exp_g;
        logic       exp_v;
        do_reset();
        for (int k = 0; k < 9; k++) begin
            bus.req   = (k < 6) ? 3'b111 : 3'b000;
            bus.req_x = 9'($urandom);
            @(negedge clk);
            if (k < 6) begin
                exp_g = 3'b001 << (k % 3);
                checks++; if (bus.gnt !== exp_g) begin errors++; $display("FAIL b2b_gnt k%0d got %b want %b", k, bus.gnt, exp_g); end
            end
            exp_v = (k >= 2 && k < 8);
            checks++; if (bus.rsp_valid !== exp_v) begin errors++; $display("FAIL b2b_rsp_valid k%0d got %b want %b", k, bus.rsp_valid, exp_v); end
            if (exp_v) begin
                checks++; if (bus.rsp_id !== 2'((k - 2) % 3)) begin errors++; $display("FAIL b2b_rsp_id k%0d got %0d want %0d", k, bus.rsp_id, (k - 2) % 3); end
            end
            if (k == 8) begin
                checks++; if (bus.step_cnt !== CNT_W'(6)) begin errors++; $display("FAIL b2b_step_cnt got %0d want 6", bus.step_cnt); end
            end
            next_cycle();
        end
    endtask

    task automatic test_lock();
        logic [2:0] rq [9];
        logic [2:0] lk [9];
        logic [2:0] ex [9];
        rq = '{3'b100, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b011, 3'b001, 3'b011};
        lk = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b000, 3'b000, 3'b011, 3'b011, 3'b001};
        ex = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b010, 3'b001, 3'b001};
        do_reset();
        for (int k = 0; k < 9; k++) begin
            bus.req = rq[k]; bus.req_lock = lk[k]; bus.req_x = '0;
            @(negedge clk);
            checks++; if (bus.gnt !== ex[k]) begin errors++; $display("FAIL lock_gnt k%0d got %b want %b", k, bus.gnt, ex[k]); end
            if (k >= 2 && k <= 5) begin
                checks++; if ({bus.rsp_valid, bus.rsp_id} !== 3'b110) begin errors++; $display("FAIL lock_rsp k%0d got v%b id%0d want v1 id2", k, bus.rsp_valid, bus.rsp_id); end
            end
            next_cycle();
        end
        bus.req = '0; bus.req_lock = '0;
    endtask

    task automatic test_clr();
        do_reset();
        bus.req = 3'b001; bus.req_x = 9'b000_000_011;
        @(negedge clk);
        checks++; if (bus.gnt !== 3'b001) begin errors++; $display("FAIL clr_pre_gnt got %b want 001", bus.gnt); end
        next_cycle();
        bus.clr = 1'b1;
        @(negedge clk);
        checks++; if (bus.gnt !== 3'b000) begin errors++; $display("FAIL clr_gnt got %b want 000", bus.gnt); end
        checks++; if (bus.fsm_nreset !== 1'b1) begin errors++; $display("FAIL clr_fsm_nreset_n got %b want 1", bus.fsm_nreset); end
        next_cycle();
        bus.clr = 1'b0; bus.req_x = 9'b000_000_001;
        @(negedge clk);
        checks++; if (bus.gnt !== 3'b001) begin errors++; $display("FAIL clr_post_gnt got %b want 001", bus.gnt); end
        checks++; if (bus.fsm_nreset !== 1'b0) begin errors++; $display("FAIL clr_fsm_nreset_n1 got %b want 0", bus.fsm_nreset); end
        checks++; if ({bus.rsp_valid, bus.rsp_y} !== 4'b1_011) begin errors++; $display("FAIL clr_inflight_rsp got v%b y%b want v1 y011", bus.rsp_valid, bus.rsp_y); end
        next_cycle();
        bus.req = 3'b000;
        @(negedge clk);
        checks++; if (bus.fsm_nreset !== 1'b1) begin errors++; $display("FAIL clr_fsm_nreset_n2 got %b want 1", bus.fsm_nreset); end
        checks++; if (bus.fsm_y !== 3'b000) begin errors++; $display("FAIL clr_fsm_y got %b want 000", bus.fsm_y); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL clr_gap_rsp got %b want 0", bus.rsp_valid); end
        next_cycle();
        bus.clr = 1'b1; bus.req = 3'b001;
        @(negedge clk);
        checks++; if ({bus.rsp_valid, bus.rsp_y, bus.rsp_z} !== 7'b1_001_001) begin errors++; $display("FAIL clr_after_rsp got v%b y%b z%b want v1 y001 z001", bus.rsp_valid, bus.rsp_y, bus.rsp_z); end
        checks++; if (bus.gnt !== 3'b000) begin errors++; $display("FAIL clr_hold_gnt0 got %b want 000", bus.gnt); end
        next_cycle();
        @(negedge clk);
        checks++; if ({bus.gnt, bus.fsm_nreset} !== 4'b000_0) begin errors++; $display("FAIL clr_hold1 got gnt%b nr%b want gnt000 nr0", bus.gnt, bus.fsm_nreset); end
        next_cycle();
        bus.clr = 1'b0;
        @(negedge clk);
        checks++; if ({bus.gnt, bus.fsm_nreset} !== 4'b001_0) begin errors++; $display("FAIL clr_hold_tail got gnt%b nr%b want gnt001 nr0", bus.gnt, bus.fsm_nreset); end
        next_cycle();
        bus.req = 3'b000;
        @(negedge clk);
        checks++; if (bus.fsm_nreset !== 1'b1) begin errors++; $display("FAIL clr_hold_end got %b want 1", bus.fsm_nreset); end
        next_cycle();
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int k = 0; k < 8; k++) begin
            nreset = (k != 3); bus.req = 3'b111; bus.req_x = '0;
            @(negedge clk);
            if (k == 2 || k == 6) begin
                checks++; if ({bus.rsp_valid, bus.rsp_id} !== 3'b100) begin errors++; $display("FAIL rmid_rsp k%0d got v%b id%0d want v1 id0", k, bus.rsp_valid, bus.rsp_id); end
            end
            if (k == 3) begin
                checks++; if (bus.gnt !== 3'b000) begin errors++; $display("FAIL rmid_gnt_in_reset got %b want 000", bus.gnt); end
            end
            if (k == 4 || k == 5) begin
                checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rmid_flushed k%0d got %b want 0", k, bus.rsp_valid); end
            end
            if (k == 4) begin
                checks++; if (bus.step_cnt !== '0) begin errors++; $display("FAIL rmid_step_cnt got %0d want 0", bus.step_cnt); end
                checks++; if ({bus.fsm_nreset, fx} !== {1'b0, IDLE_X}) begin errors++; $display("FAIL rmid_fsm got nr%b x%b want nr0 x%b", bus.fsm_nreset, fx, IDLE_X); end
                checks++; if (bus.gnt !== 3'b001) begin errors++; $display("FAIL rmid_gnt_restart got %b want 001", bus.gnt); end
            end
            next_cycle();
        end
        nreset = 1'b1; bus.req = '0;
    endtask

    task automatic test_random();
        int               ptr, last, g, ri, wi;
        logic [2:0]       my, slice, prev_x, exp_g;
        logic [CNT_W-1:0] cnt;
        bit               prev_block;
        bit               hv  [4];
        logic [1:0]       hid [4];
        logic [2:0]       hy  [4];
        logic [2:0]       hz  [4];
        ptr = 0; last = -1; my = '0; slice = '0; prev_x = IDLE_X; cnt = '0; prev_block = 1'b0;
        for (int i = 0; i < 4; i++) begin hv[i] = 1'b0; hid[i] = '0; hy[i] = '0; hz[i] = '0; end
        do_reset();
        for (int t = 0; t < 600; t++) begin
            nreset       = ($urandom_range(0, 63) != 0);
            bus.clr      = ($urandom_range(0, 11) == 0);
            bus.req      = 3'($urandom);
            bus.req_lock = ($urandom_range(0, 1) == 1) ? 3'($urandom) : 3'b000;
            bus.req_x    = 9'($urandom);
            g = -1;
            if (nreset && !bus.clr) begin
                if (last >= 0 && bus.req[last] && bus.req_lock[last]) g = last;
                else for (int k = 0; k < 3; k++) if (g < 0 && bus.req[(ptr + k) % 3]) g = (ptr + k) % 3;
            end
            exp_g = (g < 0) ? 3'b000 : 3'(1 << g);
            ri = (t + 2) % 4;
            wi = t % 4;
            @(negedge clk);
            checks++; if (bus.gnt !== exp_g) begin errors++; $display("FAIL rand_gnt t%0d got %b want %b", t, bus.gnt, exp_g); end
            checks++; if (bus.rsp_valid !== hv[ri]) begin errors++; $display("FAIL rand_rsp_valid t%0d got %b want %b", t, bus.rsp_valid, hv[ri]); end
            if (hv[ri]) begin
                checks++; if ({bus.rsp_id, bus.rsp_y, bus.rsp_z} !== {hid[ri], hy[ri], hz[ri]}) begin errors++; $display("FAIL rand_rsp t%0d got id%0d y%b z%b want id%0d y%b z%b", t, bus.rsp_id, bus.rsp_y, bus.rsp_z, hid[ri], hy[ri], hz[ri]); end
            end
            checks++; if (bus.fsm_nreset !== !prev_block) begin errors++; $display("FAIL rand_fsm_nreset t%0d got %b want %b", t, bus.fsm_nreset, !prev_block); end
            checks++; if (fx !== prev_x) begin errors++; $display("FAIL rand_fsm_x t%0d got %b want %b", t, fx, prev_x); end
            checks++; if (bus.step_cnt !== cnt) begin errors++; $display("FAIL rand_step_cnt t%0d got %0d want %0d", t, bus.step_cnt, cnt); end
            if (hv[ri]) cnt = cnt + CNT_W'(1);
            hv[wi] = (g >= 0);
            if (g >= 0) begin
                slice   = bus.req_x[3*g +: 3];
                my      = my + slice;
                hid[wi] = 2'(g);
                hy[wi]  = my;
                hz[wi]  = slice;
                ptr     = (g + 1) % 3;
                last    = g;
            end
            prev_x = (g >= 0) ? slice : IDLE_X;
            if (nreset && bus.clr) my = 3'b000;
            prev_block = !nreset || bus.clr;
            if (!nreset) begin
                ptr = 0; last = -1; my = '0; cnt = '0; prev_x = IDLE_X;
                for (int i = 0; i < 4; i++) hv[i] = 1'b0;
            end
            next_cycle();
        end
        nreset = 1'b1; bus.clr = 1'b0; bus.req = '0; bus.req_lock = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_lock();
        test_clr();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
